pipe_seg_skid_reg: RTL

- Generic, parametrised pipeline segment register for the ysyx23060136 core, replacing hand-written per-stage registers (IFU→IDU, IDU→EXU, EXU→MEM, MEM→WBU).
- Carries an opaque payload vector plus memory-op flags over a valid/ready handshake, with an optional 2-entry skid buffer that breaks the ready timing path.
- Provides synchronous flush, plus one-cycle memory-request pulses generated when a new memory op first reaches the output.

---
 rtl/pipe_seg_skid_reg_pkg.sv | 60 ++++++
 rtl/pipe_seg_skid_reg_slot.sv | 39 +++
 rtl/pipe_seg_skid_reg.sv | 111 +++++++++++
 3 files changed

// File: rtl/pipe_seg_skid_reg_pkg.sv
// Shared types for pipeline segment registers: per-stage payload layouts,
// their reset values and pack/unpack helpers for the opaque payload vector.
package pipe_seg_pkg_ysyx23060136;

  localparam int unsigned    SEG_PAYLOAD_W = 160;
  localparam logic [31:0]    PC_RST        = 32'h8000_0000;
  localparam logic [31:0]    NOP           = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifu_idu_payload_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
  } idu_exu_payload_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_res;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        rf_wen;
  } exu_mem_payload_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        rf_wen;
  } mem_wbu_payload_t;

  localparam ifu_idu_payload_t IFU_IDU_RST = '{pc: PC_RST, inst: NOP};
  localparam idu_exu_payload_t IDU_EXU_RST = '{pc: PC_RST, inst: NOP, rs1_val: '0, rs2_val: '0, imm: '0};
  localparam exu_mem_payload_t EXU_MEM_RST = '{pc: PC_RST, alu_res: '0, wdata: '0, rd: '0, funct3: '0, rf_wen: 1'b0};
  localparam mem_wbu_payload_t MEM_WBU_RST = '{pc: PC_RST, wb_data: '0, rd: '0, rf_wen: 1'b0};

  // Stages zero-extend their struct into the generic payload; unpack takes the low slice.
  function automatic logic [SEG_PAYLOAD_W-1:0] pack_exu_mem(input exu_mem_payload_t p);
    return SEG_PAYLOAD_W'(p);
  endfunction

  function automatic exu_mem_payload_t unpack_exu_mem(input logic [$bits(exu_mem_payload_t)-1:0] w);
    return exu_mem_payload_t'(w);
  endfunction

  function automatic logic [SEG_PAYLOAD_W-1:0] pack_mem_wbu(input mem_wbu_payload_t p);
    return SEG_PAYLOAD_W'(p);
  endfunction

  function automatic mem_wbu_payload_t unpack_mem_wbu(input logic [$bits(mem_wbu_payload_t)-1:0] w);
    return mem_wbu_payload_t'(w);
  endfunction

endpackage

// File: rtl/pipe_seg_skid_reg_slot.sv
// One held pipeline entry: valid + payload + mem flags, with clear over load priority.
module pipe_seg_slot_ysyx23060136 #(
  parameter int unsigned       W   = 160,
  parameter logic [W-1:0]      RST = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic         d_valid,
  input  logic [W-1:0] d_payload,
  input  logic         d_rd,
  input  logic         d_wr,
  output logic         q_valid,
  output logic [W-1:0] q_payload,
  output logic         q_rd,
  output logic         q_wr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid   <= 1'b0;
      q_payload <= RST;
      q_rd      <= 1'b0;
      q_wr      <= 1'b0;
    end else if (clr) begin
      q_valid   <= 1'b0;
      q_payload <= RST;
      q_rd      <= 1'b0;
      q_wr      <= 1'b0;
    end else if (ld) begin
      q_valid   <= d_valid;
      q_payload <= d_payload;
      q_rd      <= d_rd & d_valid;
      q_wr      <= d_wr & d_valid;
    end
  end

endmodule

// File: rtl/pipe_seg_skid_reg.sv
// Generic pipeline segment register: registered output slot M, optional skid slot S
// that makes up_ready_o a pure register, plus one-shot mem request pulses.
module pipe_seg_skid_reg
  import pipe_seg_pkg_ysyx23060136::*;
#(
  parameter int unsigned          PAYLOAD_W   = 160,
  parameter logic [PAYLOAD_W-1:0] RST_PAYLOAD = '0,
  parameter bit                   SKID_EN     = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 up_valid_i,
  output logic                 up_ready_o,
  input  logic [PAYLOAD_W-1:0] up_payload_i,
  input  logic                 up_mem_rd_i,
  input  logic                 up_mem_wr_i,
  output logic                 dn_valid_o,
  input  logic                 dn_ready_i,
  output logic [PAYLOAD_W-1:0] dn_payload_o,
  output logic                 dn_mem_rd_o,
  output logic                 dn_mem_wr_o,
  output logic                 dn_rd_req_o,
  output logic                 dn_wr_req_o,
  output logic [1:0]           occupancy_o
);

  logic                 up_fire, dn_fire;
  logic                 m_valid, m_rd, m_wr;
  logic [PAYLOAD_W-1:0] m_payload;
  logic                 s_valid, s_rd, s_wr;
  logic [PAYLOAD_W-1:0] s_payload;
  logic                 m_ld, m_d_valid, m_d_rd, m_d_wr;
  logic [PAYLOAD_W-1:0] m_d_payload;

  assign up_fire = up_valid_i & up_ready_o;
  assign dn_fire = m_valid & dn_ready_i;

  // S drains into M first; otherwise M takes upstream when it is free or moving on.
  always_comb begin
    m_ld        = 1'b0;
    m_d_valid   = 1'b0;
    m_d_payload = up_payload_i;
    m_d_rd      = up_mem_rd_i;
    m_d_wr      = up_mem_wr_i;
    if (s_valid && dn_fire) begin
      m_ld        = 1'b1;
      m_d_valid   = 1'b1;
      m_d_payload = s_payload;
      m_d_rd      = s_rd;
      m_d_wr      = s_wr;
    end else if (up_fire && (!m_valid || dn_fire)) begin
      m_ld      = 1'b1;
      m_d_valid = 1'b1;
    end else if (dn_fire) begin
      m_ld = 1'b1;
    end
  end

  pipe_seg_slot_ysyx23060136 #(.W(PAYLOAD_W), .RST(RST_PAYLOAD)) u_m (
    .clk(clk), .rst(rst), .clr(flush_i), .ld(m_ld), .d_valid(m_d_valid),
    .d_payload(m_d_payload), .d_rd(m_d_rd), .d_wr(m_d_wr),
    .q_valid(m_valid), .q_payload(m_payload), .q_rd(m_rd), .q_wr(m_wr)
  );

  generate
    if (SKID_EN) begin : g_skid
      logic s_ld, s_d_valid;
      always_comb begin
        s_d_valid = up_fire & m_valid & ~dn_fire;
        s_ld      = s_d_valid | (dn_fire & s_valid);
      end
      pipe_seg_slot_ysyx23060136 #(.W(PAYLOAD_W), .RST(RST_PAYLOAD)) u_s (
        .clk(clk), .rst(rst), .clr(flush_i), .ld(s_ld), .d_valid(s_d_valid),
        .d_payload(up_payload_i), .d_rd(up_mem_rd_i), .d_wr(up_mem_wr_i),
        .q_valid(s_valid), .q_payload(s_payload), .q_rd(s_rd), .q_wr(s_wr)
      );
      assign up_ready_o = ~s_valid;
    end else begin : g_noskid
      assign s_valid    = 1'b0;
      assign s_payload  = RST_PAYLOAD;
      assign s_rd       = 1'b0;
      assign s_wr       = 1'b0;
      assign up_ready_o = ~m_valid | dn_ready_i;
    end
  endgenerate

  // A pulse marks the first cycle a freshly loaded M entry is visible downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dn_rd_req_o <= 1'b0;
      dn_wr_req_o <= 1'b0;
    end else if (flush_i) begin
      dn_rd_req_o <= 1'b0;
      dn_wr_req_o <= 1'b0;
    end else begin
      dn_rd_req_o <= m_ld & m_d_valid & m_d_rd;
      dn_wr_req_o <= m_ld & m_d_valid & m_d_wr;
    end
  end

  assign dn_valid_o   = m_valid;
  assign dn_payload_o = m_payload;
  assign dn_mem_rd_o  = m_valid & m_rd;
  assign dn_mem_wr_o  = m_valid & m_wr;
  assign occupancy_o  = {1'b0, m_valid} + {1'b0, s_valid};

  a_rd_wr_excl: assert property (@(posedge clk) disable iff (rst)
    up_valid_i |-> !(up_mem_rd_i && up_mem_wr_i));

endmodule
